mod_step_counter: RTL and testbench

Parametrised up/down modulo counter with programmable step, synchronous load/clear, and wrap or saturate overflow handling. Generalised successor of the team's fixed 8-bit enable-gated incrementer. Used wherever a datapath needs a configurable event, address or timeout counter. Flags the exact cycle of every limit crossing to downstream control.

---
 rtl/counter_pkg.sv | 53 +++++
 rtl/counter_prescaler.sv | 26 ++
 rtl/mod_step_counter.sv | 84 ++++++++
 tb/tb_mod_step_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and the limit arithmetic used by the step counters.
package counter_pkg;

    localparam int CNT_MAX_W = 32;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;
    typedef enum logic {OVF_WRAP = 1'b0, OVF_SAT = 1'b1} ovf_mode_e;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] count;
        logic                 wrap;
        logic                 sat;
    } limit_res_t;

    // Next count for one tick of size step inside 0..mod_val, with wrap/sat flags.
    function automatic limit_res_t limit_calc(
        input logic [CNT_MAX_W-1:0] count,
        input logic [CNT_MAX_W-1:0] step,
        input logic [CNT_MAX_W-1:0] mod_val,
        input count_dir_e           dir,
        input ovf_mode_e            mode
    );
        logic [CNT_MAX_W:0] sum;
        logic [CNT_MAX_W:0] span;
        limit_res_t         r;
        sum  = {1'b0, count} + {1'b0, step};
        span = {1'b0, mod_val} + (CNT_MAX_W+1)'(1);
        r    = '0;
        if (dir == DIR_UP) begin
            if (sum <= {1'b0, mod_val}) begin
                r.count = CNT_MAX_W'(sum);
            end else if (mode == OVF_WRAP) begin
                r.count = CNT_MAX_W'(sum - span);
                r.wrap  = 1'b1;
            end else begin
                r.count = mod_val;
                r.sat   = 1'b1;
            end
        end else begin
            if (step <= count) begin
                r.count = count - step;
            end else if (mode == OVF_WRAP) begin
                r.count = CNT_MAX_W'({1'b0, count} + span - {1'b0, step});
                r.wrap  = 1'b1;
            end else begin
                r.count = '0;
                r.sat   = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits a tick every prescale+1 enabled cycles; frozen while enable is low.
module counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // >= rather than == so a prescale lowered below the running phase still ticks promptly.
    assign tick = enable && !restart && (cnt_q >= prescale);

    // Phase advance: restart wins, idle cycles freeze, a tick returns to zero.
    always_comb cnt_d = restart ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;

    // Phase register.
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/mod_step_counter.sv
// mod_step_counter: up/down modulo counter with programmable step, load/clear and wrap/saturate.
// Optional prescaler enabled by defining MOD_STEP_COUNTER_PRESCALE_EN.
module mod_step_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] MOD_VAL    = '1,
    parameter int               STEP_W     = 4,
    parameter int               PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  enable,
    input  logic                  dir,
    input  logic [STEP_W-1:0]     step,
    input  logic                  sat_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  wrap,
    output logic                  sat
);

    logic [WIDTH-1:0]     count_q, count_d;
    logic                 wrap_q, wrap_d;
    logic                 sat_q, sat_d;
    logic                 tick;
    limit_res_t           lim;
    logic [CNT_MAX_W-1:0] lim_unused;

`ifdef MOD_STEP_COUNTER_PRESCALE_EN
    counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .restart  (clr | load),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    logic [PRESCALE_W-1:0] prescale_unused;
    assign prescale_unused = prescale;
    assign tick            = enable;
`endif

    assign lim = limit_calc(CNT_MAX_W'(count_q), CNT_MAX_W'(step), CNT_MAX_W'(MOD_VAL),
                            count_dir_e'(dir), ovf_mode_e'(sat_mode));
    assign lim_unused = lim.count;

    // Next state: clear beats load beats tick; flags only ever reflect the current update.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MOD_VAL) ? MOD_VAL : load_val;
        end else if (tick) begin
            count_d = lim.count[WIDTH-1:0];
            wrap_d  = lim.wrap;
            sat_d   = lim.sat;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_mod_step_counter.sv
// tb_mod_step_counter: table-driven scoreboard bench for mod_step_counter (MOD_VAL = 9 plus a full-range copy).
module tb_mod_step_counter;
    localparam int MOD = 9;
`ifdef MOD_STEP_COUNTER_PRESCALE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0, load = 1'b0, enable = 1'b0, dir = 1'b0, sat_mode = 1'b0;
    logic [7:0] load_val = '0;
    logic [3:0] step = '0, prescale = '0;
    logic [7:0] cnt_a, cnt_b;
    logic       wrap_a, sat_a, wrap_b, sat_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_step_counter #(.WIDTH(8), .MOD_VAL(8'd9), .STEP_W(4), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .enable(enable),
        .dir(dir), .step(step), .sat_mode(sat_mode), .prescale(prescale),
        .count(cnt_a), .wrap(wrap_a), .sat(sat_a)
    );

    mod_step_counter #(.WIDTH(8), .STEP_W(4), .PRESCALE_W(4)) dut_full (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .enable(enable),
        .dir(dir), .step(step), .sat_mode(sat_mode), .prescale(prescale),
        .count(cnt_b), .wrap(wrap_b), .sat(sat_b)
    );

    always @(posedge clk)
        if (!rst && enable) assert (int'(step) <= MOD + 1) else $error("illegal step %0d", step);

    typedef struct {
        logic [7:0] cnt;
        logic       w;
        logic       s;
    } exp_t;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic       dir;
        logic [3:0] st;
        logic       sm;
        logic [7:0] cnt;
        logic       w;
        logic       s;
        string      nm;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[16];

    task automatic cmp(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic check(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            checks++;
            if (cnt_a !== e.cnt || wrap_a !== e.w || sat_a !== e.s) begin
                errors++;
                $display("FAIL %s: got count=%0d wrap=%b sat=%b expected count=%0d wrap=%b sat=%b",
                         nm, cnt_a, wrap_a, sat_a, e.cnt, e.w, e.s);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        clr = v.clr; load = v.load; load_val = v.lv; enable = v.en;
        dir = v.dir; step = v.st; sat_mode = v.sm;
        sbq.push_back('{v.cnt, v.w, v.s});
        @(posedge clk);
        #1 check(v.nm);
    endtask

    initial begin
        int n;
        vec_t v;
        tbl[0]  = '{0, 1, 8'd8,   0, 1, 4'd0,  0, 8'd8, 0, 0, "load8"};
        tbl[1]  = '{0, 0, 8'd0,   1, 1, 4'd3,  0, 8'd1, 1, 0, "wrap_up"};
        tbl[2]  = '{0, 0, 8'd0,   0, 1, 4'd3,  0, 8'd1, 0, 0, "wrap_one_cycle"};
        tbl[3]  = '{0, 0, 8'd0,   1, 1, 4'd3,  0, 8'd4, 0, 0, "up_plain"};
        tbl[4]  = '{0, 0, 8'd0,   1, 0, 4'd5,  0, 8'd9, 1, 0, "wrap_down"};
        tbl[5]  = '{0, 1, 8'd2,   0, 0, 4'd5,  1, 8'd2, 0, 0, "load2"};
        tbl[6]  = '{0, 0, 8'd0,   1, 0, 4'd5,  1, 8'd0, 0, 1, "sat_down1"};
        tbl[7]  = '{0, 0, 8'd0,   1, 0, 4'd5,  1, 8'd0, 0, 1, "sat_down2"};
        tbl[8]  = '{0, 0, 8'd0,   1, 1, 4'd9,  1, 8'd9, 0, 0, "up_to_max"};
        tbl[9]  = '{0, 0, 8'd0,   1, 1, 4'd1,  1, 8'd9, 0, 1, "sat_up_hold"};
        tbl[10] = '{0, 0, 8'd0,   1, 1, 4'd10, 0, 8'd9, 1, 0, "wrap_full_step"};
        tbl[11] = '{1, 1, 8'hFF,  1, 1, 4'd1,  0, 8'd0, 0, 0, "prio_clr"};
        tbl[12] = '{0, 1, 8'hFF,  0, 1, 4'd1,  0, 8'd9, 0, 0, "load_clamp"};
        tbl[13] = '{0, 0, 8'd0,   1, 0, 4'd0,  1, 8'd9, 0, 0, "step0_down"};
        tbl[14] = '{0, 0, 8'd0,   1, 1, 4'd7,  0, 8'd6, 1, 0, "wrap_up7"};
        tbl[15] = '{0, 0, 8'd0,   1, 1, 4'd4,  0, 8'd0, 1, 0, "wrap_to_zero"};

        repeat (2) @(posedge clk);
        #1;
        cmp("reset_count", int'(cnt_a), 0);
        cmp("reset_flags", int'({wrap_a, sat_a}), 0);
        @(negedge clk) rst = 1'b0;

        foreach (tbl[i]) drive(tbl[i]);

        for (int i = 0; i < 10; i++) begin
            v = '{0, 0, 8'd0, 1, i[0], 4'd0, i[1], 8'd0, 0, 0, "step0_hold"};
            drive(v);
        end

        v = '{1, 0, 8'd0, 0, 1, 4'd0, 0, 8'd0, 0, 0, "pre_clr"};
        drive(v);
        prescale = 4'd2;
        n = 0;
        for (int i = 0; i < 13; i++) begin
            logic en;
            en = !(i >= 4 && i < 8);
            if (en) n++;
            v = '{0, 0, 8'd0, en, 1, 4'd1, 0, 8'(PRE ? n / 3 : n), 0, 0, "prescale_seq"};
            drive(v);
        end
        prescale = 4'd0;

        @(negedge clk);
        clr = 1'b0; load = 1'b1; load_val = 8'h37; enable = 1'b0;
        @(posedge clk);
        #1 cmp("full_load37", int'(cnt_b), 'h37);
        @(negedge clk);
        load = 1'b0; enable = 1'b1; dir = 1'b1; step = 4'd1; sat_mode = 1'b1;
        @(posedge clk);
        #1;
        cmp("pre_rst_sat", int'({cnt_a, sat_a}), (9 << 1) | 1);
        cmp("full_count38", int'(cnt_b), 'h38);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_count", int'(cnt_a), 0);
        cmp("async_rst_flags", int'({wrap_a, sat_a}), 0);
        cmp("async_rst_full", int'(cnt_b), 0);
        enable = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 cmp("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
